uart_apb_sequencer: RTL and testbench
=====================================

Name: uart_apb_sequencer

Overview:
- APB master that sequences the UART APB register slave.
- Programs the baud register, then shares the single APB port between a host TX byte stream and automatic RX draining.
- RX is drained whenever the UART flags received data.
- Sits between system-side byte producers/consumers and the UART APB slave; owns all APB traffic to it.

Parameters:
- BITWIDTH, 8, width of APB data, baud value and byte paths.
- HOLDOFF, 4, cycles after a TX/RX transfer during which tx_rdy/rx_rdy are ignored (status settle time).
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before the transfer is aborted.

Ports:
- pclk  in  1  clock; all flops rising-edge.
- presetn  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse: write cfg_baud to register 0.
- cfg_baud  in  BITWIDTH  baud divisor value, sampled on cfg_start.
- tx_req  in  1  host byte valid; held until tx_ack.
- tx_data  in  BITWIDTH  host byte; stable while tx_req=1.
- tx_ack  out  1  one-cycle pulse when the byte write completes.
- rx_valid  out  1  one-cycle pulse, rx_data valid.
- rx_data  out  BITWIDTH  byte read from register 3.
- tx_rdy  in  1  UART transmit-ready status.
- rx_rdy  in  1  UART receive-ready status.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  2  APB address.
- pwdata  out  BITWIDTH  APB write data.
- prdata  in  BITWIDTH  APB read data.
- pready  in  1  APB ready.
- cfg_done  out  1  level; set after a successful baud write.
- busy  out  1  high in SETUP/ACCESS or while HOLDOFF is counting.
- err  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset values: all outputs 0; paddr=0; pwdata=0; rx_data=0; state IDLE; holdoff counter 0; pending-config flag 0.
- cfg_start arriving in any state sets the pending-config flag (latches cfg_baud). A second cfg_start before service overwrites the latched value.
- States:
  - IDLE: choose a request by fixed priority:
    1. pending config: write, paddr=0, pwdata=latched baud.
    2. rx_rdy and holdoff==0: read, paddr=3.
    3. tx_req and tx_rdy and cfg_done and holdoff==0: write, paddr=2, pwdata=tx_data.
    - If no request qualifies, stay in IDLE with psel=0.
  - SETUP (1 cycle): psel=1, penable=0. paddr/pwrite/pwdata are registered on entry and stable until return to IDLE.
  - ACCESS: psel=1, penable=1. Stay while pready=0.
    - On pready=1: complete, go to IDLE, drop psel/penable next cycle.
    - Read completion: rx_data<=prdata and rx_valid pulses on the following cycle.
    - TX write completion: tx_ack pulses.
    - Config write completion: cfg_done<=1, pending flag cleared.
    - After a TX or RX completion (not config), load the holdoff counter with HOLDOFF; it decrements to 0 each cycle.
    - Timeout: TIMEOUT consecutive ACCESS cycles with pready=0 abort the transfer. Pulse err and return to IDLE.
    - An aborted transfer produces no ack/valid/cfg_done. The request stays pending: tx_req is still held, and the config flag is not cleared.
- Arbitration is decided only in IDLE; a transfer in flight is never pre-empted.
- Minimum transfer is 2 cycles (SETUP + ACCESS with pready=1) plus 1 IDLE cycle, so back-to-back transfers are spaced 3 cycles apart.
- TX is blocked until cfg_done=1; RX reads are allowed before configuration.
- presetn asserted mid-transfer: APB outputs drop to 0 immediately (asynchronous). Pending config, cfg_done and holdoff all clear.
- HOLDOFF=0 disables holdoff. Counter width is clog2(HOLDOFF+1), minimum 1.

Test Plan:
- Reset, then cfg_start with cfg_baud=8'h1A, pready=1 → SETUP then ACCESS at paddr=0, pwrite=1, pwdata=8'h1A; cfg_done=1 the cycle after ACCESS; no err.
- After config: tx_rdy=1, tx_req with tx_data=8'h55 → write to paddr=2, pwdata=8'h55; tx_ack single pulse. A second byte 8'hAA is not started until HOLDOFF=4 cycles have elapsed.
- rx_rdy=1 and tx_req both pending in IDLE → read of paddr=3 issued first; prdata=8'hC3 gives rx_data=8'hC3 with one rx_valid pulse; TX write follows after holdoff.
- pready held 0 for 16 ACCESS cycles on a TX write → err pulse, return to IDLE, no tx_ack; write is retried with pready=1 and tx_ack follows.
- tx_req=1 before any cfg_start → no APB activity, psel stays 0. Then cfg_start: config write precedes the TX write.
- presetn pulled low during ACCESS → psel/penable/cfg_done drop to 0 immediately; after release the block is IDLE and TX is blocked until reconfigured.

Source files
------------

// File: rtl/uart_apb_sequencer.sv
// APB master for the UART register slave: baud setup, host TX writes
// and automatic RX draining, all sharing one APB port.
module uart_apb_sequencer #(
    parameter int BITWIDTH = 8,
    parameter int HOLDOFF  = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                cfg_start,
    input  logic [BITWIDTH-1:0] cfg_baud,
    input  logic                tx_req,
    input  logic [BITWIDTH-1:0] tx_data,
    output logic                tx_ack,
    output logic                rx_valid,
    output logic [BITWIDTH-1:0] rx_data,
    input  logic                tx_rdy,
    input  logic                rx_rdy,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [1:0]          paddr,
    output logic [BITWIDTH-1:0] pwdata,
    input  logic [BITWIDTH-1:0] prdata,
    input  logic                pready,
    output logic                cfg_done,
    output logic                busy,
    output logic                err
);

    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef enum logic [1:0] {K_CFG, K_RX, K_TX} kind_t;

    state_t              state;
    kind_t               kind;
    logic [HW-1:0]       hold;
    logic [TW-1:0]       tcnt;
    logic                cfg_pend;
    logic [BITWIDTH-1:0] cfg_val;
    logic                rx_go;
    logic                tx_go;

    // tx_ack blocks a re-issue while the host still holds tx_req that cycle
    assign rx_go = rx_rdy && (hold == '0);
    assign tx_go = tx_req && tx_rdy && cfg_done && (hold == '0) && !tx_ack;
    assign busy  = (state != IDLE) || (hold != '0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            kind     <= K_CFG;
            hold     <= '0;
            tcnt     <= '0;
            cfg_pend <= 1'b0;
            cfg_val  <= '0;
            cfg_done <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= 2'd0;
            pwdata   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_ack   <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            err      <= 1'b0;
            if (hold != '0) hold <= hold - 1'b1;
            unique case (state)
                IDLE: begin
                    if (cfg_pend) begin
                        kind   <= K_CFG;
                        pwrite <= 1'b1;
                        paddr  <= 2'd0;
                        pwdata <= cfg_val;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end else if (rx_go) begin
                        kind   <= K_RX;
                        pwrite <= 1'b0;
                        paddr  <= 2'd3;
                        pwdata <= '0;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end else if (tx_go) begin
                        kind   <= K_TX;
                        pwrite <= 1'b1;
                        paddr  <= 2'd2;
                        pwdata <= tx_data;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                        unique case (kind)
                            K_CFG: begin
                                cfg_done <= 1'b1;
                                cfg_pend <= 1'b0;
                            end
                            K_RX: begin
                                rx_data  <= prdata;
                                rx_valid <= 1'b1;
                                hold     <= HW'(HOLDOFF);
                            end
                            K_TX: begin
                                tx_ack <= 1'b1;
                                hold   <= HW'(HOLDOFF);
                            end
                            default: ;
                        endcase
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // abort leaves the request pending for a retry
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // a new request landing on the completion edge stays pending
            if (cfg_start) begin
                cfg_pend <= 1'b1;
                cfg_val  <= cfg_baud;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Bench for uart_apb_sequencer: APB slave/UART model, scenario tasks
// and a randomized TX/RX mix checked against expected byte streams.
module tb_uart_apb_sequencer;

    localparam int BW = 8;
    localparam int HO = 4;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b1;
    logic          cfg_start = 1'b0;
    logic [BW-1:0] cfg_baud = '0;
    logic          tx_req = 1'b0;
    logic [BW-1:0] tx_data = '0;
    logic          tx_ack;
    logic          rx_valid;
    logic [BW-1:0] rx_data;
    logic          tx_rdy = 1'b0;
    logic          rx_rdy = 1'b0;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [1:0]    paddr;
    logic [BW-1:0] pwdata;
    logic [BW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          cfg_done;
    logic          busy;
    logic          err;

    always #5 pclk = ~pclk;

    uart_apb_sequencer #(.BITWIDTH(BW), .HOLDOFF(HO), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cfg_start(cfg_start), .cfg_baud(cfg_baud),
        .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_rdy(tx_rdy), .rx_rdy(rx_rdy),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .cfg_done(cfg_done), .busy(busy), .err(err)
    );

    typedef struct {
        int         s;
        int         d;
        logic       w;
        logic [1:0] a;
        logic [7:0] wd;
        logic [7:0] rd;
    } xfer_t;

    xfer_t      xq[$];
    logic [7:0] rxv_q[$];
    logic [7:0] rx_src[64];
    int         rx_wr = 0;
    int         rx_rd = 0;
    int         cyc = 0;
    int         acc = 0;
    int         ws = 0;
    logic       stall = 1'b0;
    logic       do_pop = 1'b0;
    int         ack_n = 0;
    int         err_n = 0;
    int         err_cyc = 0;
    int         cfg_cyc = 0;
    int         rxv_cyc = 0;
    int         cur_s = 0;
    logic       cur_w = 1'b0;
    logic [1:0] cur_a = 2'd0;
    logic [7:0] cur_wd = 8'h00;
    logic       cfg_prev = 1'b0;
    int         checks = 0;
    int         failures = 0;

    // APB slave + UART status model and transaction monitor
    always @(negedge pclk) begin
        xfer_t x;
        cyc++;
        if (do_pop) begin
            rx_rd++;
            do_pop = 1'b0;
        end
        if (psel && !penable) begin
            cur_s  = cyc;
            cur_w  = pwrite;
            cur_a  = paddr;
            cur_wd = pwdata;
        end
        acc    = (psel && penable) ? acc + 1 : 0;
        pready = psel && penable && !stall && (acc > ws);
        rx_rdy = (rx_rd < rx_wr);
        prdata = (rx_rd < rx_wr) ? rx_src[rx_rd % 64] : 8'h00;
        if (psel && penable && pready) begin
            x.s  = cur_s;
            x.d  = cyc;
            x.w  = cur_w;
            x.a  = cur_a;
            x.wd = cur_wd;
            x.rd = prdata;
            xq.push_back(x);
            if (!pwrite) do_pop = 1'b1;
        end
        if (tx_ack) ack_n++;
        if (err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (rx_valid) begin
            rxv_q.push_back(rx_data);
            rxv_cyc = cyc;
        end
        if (cfg_done && !cfg_prev) cfg_cyc = cyc;
        cfg_prev = cfg_done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    function automatic xfer_t xf(input int i);
        xfer_t z;
        z = '{s: -1000, d: 0, w: 1'b0, a: 2'd0, wd: 8'h00, rd: 8'h00};
        if (i >= 0 && i < xq.size()) return xq[i];
        return z;
    endfunction

    task automatic push_rx(input logic [7:0] b);
        rx_src[rx_wr % 64] = b;
        rx_wr++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
        tx_data = b;
        tx_req  = 1'b1;
        ok      = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            tick();
            if (tx_ack) ok = 1'b1;
        end
        tx_req = 1'b0;
    endtask

    task automatic configure(input logic [7:0] b, output bit ok);
        cfg_baud  = b;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            tick();
            if (cfg_done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b1;
        #2;
        presetn = 1'b0;
        tick();
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 13'd0) begin
            failures++;
            $display("FAIL reset_apb: got %h want 0", {psel, penable, pwrite, paddr, pwdata});
        end
        checks++;
        if ({tx_ack, rx_valid, rx_data, cfg_done, busy, err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_status: got %h want 0",
                     {tx_ack, rx_valid, rx_data, cfg_done, busy, err});
        end
        repeat (2) tick();
        presetn = 1'b1;
        repeat (3) tick();
        checks++;
        if (psel !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got psel=%b busy=%b want 0 0", psel, busy);
        end
    endtask

    task automatic test_config();
        int    n0 = xq.size();
        int    e0 = err_n;
        bit    ok;
        xfer_t x;
        configure(8'h1A, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cfg_done_seen: got %b want 1", cfg_done);
        end
        x = xf(n0);
        checks++;
        if (xq.size() != n0 + 1 || {x.a, x.w, x.wd} !== {2'd0, 1'b1, 8'h1A}) begin
            failures++;
            $display("FAIL cfg_write: got n=%0d a=%0d w=%b d=%h want n=%0d a=0 w=1 d=1a",
                     xq.size(), x.a, x.w, x.wd, n0 + 1);
        end
        checks++;
        if (x.d - x.s != 1) begin
            failures++;
            $display("FAIL cfg_access_len: got %0d want 1", x.d - x.s);
        end
        checks++;
        if (cfg_cyc != x.d + 1) begin
            failures++;
            $display("FAIL cfg_done_time: got %0d want %0d", cfg_cyc, x.d + 1);
        end
        checks++;
        if (err_n != e0) begin
            failures++;
            $display("FAIL cfg_err: got %0d want %0d", err_n - e0, 0);
        end
    endtask

    task automatic test_tx_holdoff();
        int    n0 = xq.size();
        int    a0 = ack_n;
        bit    ok1;
        bit    ok2;
        xfer_t x0;
        xfer_t x1;
        tx_rdy = 1'b1;
        send_byte(8'h55, 40, ok1);
        send_byte(8'hAA, 40, ok2);
        x0 = xf(n0);
        x1 = xf(n0 + 1);
        checks++;
        if (!(ok1 && ok2) || ack_n - a0 != 2) begin
            failures++;
            $display("FAIL tx_acks: got ok=%b%b acks=%0d want 11 2", ok1, ok2, ack_n - a0);
        end
        checks++;
        if ({x0.a, x0.w, x0.wd} !== {2'd2, 1'b1, 8'h55}) begin
            failures++;
            $display("FAIL tx_first: got a=%0d w=%b d=%h want 2 1 55", x0.a, x0.w, x0.wd);
        end
        checks++;
        if ({x1.a, x1.w, x1.wd} !== {2'd2, 1'b1, 8'hAA}) begin
            failures++;
            $display("FAIL tx_second: got a=%0d w=%b d=%h want 2 1 aa", x1.a, x1.w, x1.wd);
        end
        checks++;
        if (x1.s - x0.d != HO + 2) begin
            failures++;
            $display("FAIL tx_holdoff_gap: got %0d want %0d", x1.s - x0.d, HO + 2);
        end
    endtask

    task automatic test_rx_priority();
        int    n0 = xq.size();
        int    r0 = rxv_q.size();
        bit    ok;
        xfer_t xp;
        xfer_t xr;
        xfer_t xt;
        push_rx(8'hC3);
        send_byte(8'h3C, 60, ok);
        xp = xf(n0 - 1);
        xr = xf(n0);
        xt = xf(n0 + 1);
        checks++;
        if ({xr.a, xr.w, xr.rd} !== {2'd3, 1'b0, 8'hC3}) begin
            failures++;
            $display("FAIL rx_first: got a=%0d w=%b d=%h want 3 0 c3", xr.a, xr.w, xr.rd);
        end
        checks++;
        if (!ok || {xt.a, xt.w, xt.wd} !== {2'd2, 1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL rx_then_tx: got ok=%b a=%0d d=%h want 1 2 3c", ok, xt.a, xt.wd);
        end
        checks++;
        if (xr.s - xp.d != HO + 2 || xt.s - xr.d != HO + 2) begin
            failures++;
            $display("FAIL rx_gaps: got %0d %0d want %0d %0d",
                     xr.s - xp.d, xt.s - xr.d, HO + 2, HO + 2);
        end
        checks++;
        if (rxv_q.size() != r0 + 1 || rx_data !== 8'hC3) begin
            failures++;
            $display("FAIL rx_valid_data: got n=%0d d=%h want 1 c3", rxv_q.size() - r0, rx_data);
        end
        checks++;
        if (rxv_cyc != xr.d + 1) begin
            failures++;
            $display("FAIL rx_valid_time: got %0d want %0d", rxv_cyc, xr.d + 1);
        end
    endtask

    task automatic test_timeout();
        int    n0;
        int    a0;
        int    e0;
        int    s0;
        bit    seen = 1'b0;
        bit    ok = 1'b0;
        xfer_t x;
        repeat (8) tick();
        n0 = xq.size();
        a0 = ack_n;
        e0 = err_n;
        stall   = 1'b1;
        tx_data = 8'h77;
        tx_req  = 1'b1;
        for (int t = 0; t < 60 && !seen; t++) begin
            tick();
            if (err) seen = 1'b1;
        end
        s0 = cur_s;
        checks++;
        if (!seen || err_cyc - s0 != TO + 1) begin
            failures++;
            $display("FAIL timeout_err: got seen=%b dist=%0d want 1 %0d", seen, err_cyc - s0, TO + 1);
        end
        checks++;
        if (ack_n != a0 || xq.size() != n0) begin
            failures++;
            $display("FAIL timeout_no_ack: got acks=%0d xfers=%0d want 0 0",
                     ack_n - a0, xq.size() - n0);
        end
        stall = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            tick();
            if (tx_ack) ok = 1'b1;
        end
        tx_req = 1'b0;
        x = xf(n0);
        checks++;
        if (!ok || {x.a, x.w, x.wd} !== {2'd2, 1'b1, 8'h77}) begin
            failures++;
            $display("FAIL timeout_retry: got ok=%b a=%0d d=%h want 1 2 77", ok, x.a, x.wd);
        end
        checks++;
        if (err_n - e0 != 1) begin
            failures++;
            $display("FAIL timeout_err_pulse: got %0d want 1", err_n - e0);
        end
    endtask

    task automatic test_tx_before_cfg();
        int    n0;
        int    busy_sel = 0;
        bit    ok = 1'b0;
        xfer_t x0;
        xfer_t x1;
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        tick();
        n0 = xq.size();
        tx_rdy  = 1'b1;
        tx_data = 8'h99;
        tx_req  = 1'b1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (psel) busy_sel++;
        end
        checks++;
        if (busy_sel != 0 || cfg_done !== 1'b0) begin
            failures++;
            $display("FAIL tx_blocked: got psel_cycles=%0d cfg_done=%b want 0 0", busy_sel, cfg_done);
        end
        cfg_baud  = 8'h2B;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            tick();
            if (tx_ack) ok = 1'b1;
        end
        tx_req = 1'b0;
        x0 = xf(n0);
        x1 = xf(n0 + 1);
        checks++;
        if ({x0.a, x0.w, x0.wd} !== {2'd0, 1'b1, 8'h2B}) begin
            failures++;
            $display("FAIL cfg_first: got a=%0d w=%b d=%h want 0 1 2b", x0.a, x0.w, x0.wd);
        end
        checks++;
        if (!ok || {x1.a, x1.w, x1.wd} !== {2'd2, 1'b1, 8'h99}) begin
            failures++;
            $display("FAIL tx_after_cfg: got ok=%b a=%0d d=%h want 1 2 99", ok, x1.a, x1.wd);
        end
        checks++;
        if (x1.s - x0.d != 2) begin
            failures++;
            $display("FAIL cfg_tx_gap: got %0d want 2", x1.s - x0.d);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int sel_n = 0;
        bit hit = 1'b0;
        repeat (8) tick();
        stall   = 1'b1;
        tx_data = 8'h5A;
        tx_req  = 1'b1;
        for (int t = 0; t < 20 && !hit; t++) begin
            tick();
            if (psel && penable) hit = 1'b1;
        end
        presetn = 1'b0;
        #1;
        checks++;
        if (!hit || {psel, penable, cfg_done, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_drop: got hit=%b bits=%b want 1 0000",
                     hit, {psel, penable, cfg_done, busy});
        end
        tick();
        presetn = 1'b1;
        stall   = 1'b0;
        n0 = xq.size();
        for (int t = 0; t < 12; t++) begin
            tick();
            if (psel) sel_n++;
        end
        tx_req = 1'b0;
        checks++;
        if (sel_n != 0 || xq.size() != n0 || ack_n < 0) begin
            failures++;
            $display("FAIL mid_reset_blocked: got psel_cycles=%0d want 0", sel_n);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_tx[$];
        logic [7:0] exp_rx[$];
        logic [7:0] got_tx[$];
        logic [7:0] b;
        int         n0;
        int         r0;
        int         oks = 0;
        int         bad_gap = 0;
        int         bad_kind = 0;
        bit         ok;
        configure(8'($urandom), ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rand_cfg: got cfg_done=%b want 1", cfg_done);
        end
        n0 = xq.size();
        r0 = rxv_q.size();
        for (int i = 0; i < 14; i++) begin
            ws = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                push_rx(b);
                exp_rx.push_back(b);
            end
            b = 8'($urandom);
            exp_tx.push_back(b);
            send_byte(b, 80, ok);
            if (ok) oks++;
        end
        for (int t = 0; t < 100 && (rx_rd < rx_wr || busy); t++) tick();
        repeat (3) tick();
        ws = 0;
        for (int i = n0; i < xq.size(); i++) begin
            if (xq[i].a == 2'd2 && xq[i].w) got_tx.push_back(xq[i].wd);
            else if (!(xq[i].a == 2'd3 && !xq[i].w)) bad_kind++;
            if (i > n0 && xq[i].s - xq[i-1].d < HO + 2) bad_gap++;
        end
        checks++;
        if (oks != 14 || bad_kind != 0) begin
            failures++;
            $display("FAIL rand_acks: got acks=%0d odd=%0d want 14 0", oks, bad_kind);
        end
        checks++;
        if (bad_gap != 0) begin
            failures++;
            $display("FAIL rand_holdoff: got %0d short gaps want 0", bad_gap);
        end
        checks++;
        if (got_tx.size() != exp_tx.size() || rxv_q.size() - r0 != exp_rx.size()) begin
            failures++;
            $display("FAIL rand_counts: got tx=%0d rx=%0d want %0d %0d",
                     got_tx.size(), rxv_q.size() - r0, exp_tx.size(), exp_rx.size());
        end
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
            checks++;
            if (got_tx[i] !== exp_tx[i]) begin
                failures++;
                $display("FAIL rand_tx[%0d]: got %h want %h", i, got_tx[i], exp_tx[i]);
            end
        end
        for (int i = 0; i < exp_rx.size() && r0 + i < rxv_q.size(); i++) begin
            checks++;
            if (rxv_q[r0 + i] !== exp_rx[i]) begin
                failures++;
                $display("FAIL rand_rx[%0d]: got %h want %h", i, rxv_q[r0 + i], exp_rx[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_tx_holdoff();
        test_rx_priority();
        test_timeout();
        test_tx_before_cfg();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
